// File: rtl/spi_slave_responder_if.sv
// SPI pin bundle between a bus master and the responder target.
// Signals: spi_sclk/spi_sdi/spi_cs (master -> target, cs active low),
//          spi_sdo/spi_sdo_en (target -> master read data and its enable).
interface spi_slave_responder_if;
  logic spi_sclk;
  logic spi_sdi;
  logic spi_cs;
  logic spi_sdo;
  logic spi_sdo_en;

  modport slave (
    input  spi_sclk,
    input  spi_sdi,
    input  spi_cs,
    output spi_sdo,
    output spi_sdo_en
  );

  modport master (
    output spi_sclk,
    output spi_sdi,
    output spi_cs,
    input  spi_sdo,
    input  spi_sdo_en
  );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI target: decodes CS-framed commands into an 8-bit config register and a word memory,
// returns read data on spi_sdo. Pins are synchronized into clk_i; outputs move SYNC_STAGES+1
// clk_i cycles after the sclk pin edge. No backpressure: the master owns sclk.
// Ports: clk_i/rst_i (async active-high), spi (slave modport: sclk, sdi, cs in; sdo, sdo_en out),
//        cfg_o config register, cmd_o last command byte, frame_done / err one-cycle pulses.
module spi_slave_responder #(
  parameter int MEM_DEPTH   = 16,
  parameter int DUMMY_BITS  = 34,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  spi_slave_responder_if.slave   spi,
  output logic [7:0]             cfg_o,
  output logic [7:0]             cmd_o,
  output logic                   frame_done,
  output logic                   err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2((DUMMY_BITS > 32) ? DUMMY_BITS : 32);

  localparam logic [7:0] CMD_WRREG = 8'h01;
  localparam logic [7:0] CMD_RDREG = 8'h07;
  localparam logic [7:0] CMD_WRMEM = 8'h02;
  localparam logic [7:0] CMD_RDMEM = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_END, S_SKIP
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shift_in;
  logic [31:0]      shift_nxt;
  logic [31:0]      shift_out;
  logic [IDX_W-1:0] idx_q;
  logic             sdo_q, sdo_en_q;
  logic [31:0]      mem [MEM_DEPTH];

  // Synchronizer chains; one extra flop on sclk and cs gives the edge reference.
  logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, cs_sync;
  logic sclk_prev, cs_prev;
  logic sclk_s, sdi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  // Control strobes from the next-state logic.
  logic cmd_we, idx_we, cfg_we, mem_we, load_out, sdo_clr, done_d, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync[0] <= spi.spi_sclk;
      sdi_sync[0]  <= spi.spi_sdi;
      cs_sync[0]   <= spi.spi_cs;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        sdi_sync[i]  <= sdi_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
      end
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign shift_nxt = {shift_in[30:0], sdi_s};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_we   = 1'b0;
    idx_we   = 1'b0;
    cfg_we   = 1'b0;
    mem_we   = 1'b0;
    load_out = 1'b0;
    sdo_clr  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_CMD;
          cnt_d   = CNT_W'(7);
        end
      end
      S_SKIP: begin
        if (cs_rise) state_d = S_IDLE;
      end
      S_END: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          sdo_clr = 1'b1;
        end else if (sclk_rise) begin
          // Back-to-back: this rise already carries bit 7 of the next command.
          state_d = S_CMD;
          cnt_d   = CNT_W'(6);
          done_d  = 1'b1;
        end
      end
      default: begin
        // Active field states. cs rise has priority over a coincident sclk rise.
        if (cs_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          sdo_clr = 1'b1;
        end else if (sclk_rise) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            case (state_q)
              S_CMD: begin
                cmd_we = 1'b1;
                case (shift_nxt[7:0])
                  CMD_WRREG: begin state_d = S_WDATA; cnt_d = CNT_W'(7);  end
                  CMD_RDREG: begin state_d = S_DUMMY; cnt_d = CNT_W'(0);  end
                  CMD_WRMEM,
                  CMD_RDMEM: begin state_d = S_ADDR;  cnt_d = CNT_W'(31); end
                  default:   begin state_d = S_SKIP;  err_d = 1'b1;       end
                endcase
              end
              S_ADDR: begin
                idx_we = 1'b1;
                if (cmd_o == CMD_WRMEM) begin
                  state_d = S_WDATA;
                  cnt_d   = CNT_W'(31);
                end else begin
                  state_d = S_DUMMY;
                  cnt_d   = CNT_W'(DUMMY_BITS - 1);
                end
              end
              S_DUMMY: begin
                load_out = 1'b1;
                state_d  = S_RDATA;
                cnt_d    = CNT_W'(31);
              end
              S_RDATA: state_d = S_END;
              S_WDATA: begin
                if (cmd_o == CMD_WRREG) cfg_we = 1'b1;
                else                    mem_we = 1'b1;
                state_d = S_END;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_in   <= '0;
      shift_out  <= '0;
      idx_q      <= '0;
      cmd_o      <= '0;
      cfg_o      <= '0;
      sdo_q      <= 1'b0;
      sdo_en_q   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= done_d;
      err        <= err_d;
      if (sclk_rise) shift_in <= shift_nxt;
      if (cmd_we)    cmd_o    <= shift_nxt[7:0];
      if (idx_we)    idx_q    <= shift_nxt[IDX_W+1:2];
      if (cfg_we)    cfg_o    <= shift_nxt[7:0];
      if (load_out)  shift_out <= (cmd_o == CMD_RDREG) ? {24'h0, cfg_o} : mem[idx_q];
      if (sdo_clr) begin
        sdo_q    <= 1'b0;
        sdo_en_q <= 1'b0;
      end else if (sclk_fall) begin
        if (state_q == S_RDATA) begin
          sdo_q     <= shift_out[31];
          shift_out <= {shift_out[30:0], 1'b0};
          sdo_en_q  <= 1'b1;
        end else if (state_q == S_END) begin
          // First fall after the last read bit releases the line.
          sdo_q    <= 1'b0;
          sdo_en_q <= 1'b0;
        end
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx_q] <= shift_nxt;
  end

  assign spi.spi_sdo    = sdo_q;
  assign spi.spi_sdo_en = sdo_en_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: acts as SPI master, keeps a transaction-level
// model of cfg and memory, and compares read data, enables, pulses and registers.
module tb_spi_slave_responder;
  localparam int DEPTH = 16;
  localparam int DUMMY = 34;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] cfg_o, cmd_o;
  logic       frame_done, err;

  spi_slave_responder_if spi_if();

  spi_slave_responder #(.MEM_DEPTH(DEPTH), .DUMMY_BITS(DUMMY), .SYNC_STAGES(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .spi        (spi_if),
    .cfg_o      (cfg_o),
    .cmd_o      (cmd_o),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk_i) begin
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1)        err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0]  cfg_m;
  logic [31:0] mem_m [DEPTH];
  bit          tx_q[$];
  bit          rx_q[$];
  int          rd_pos[$];
  logic [31:0] rd_exp[$];
  int          en_cnt;
  int          n_txn;

  function automatic void push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
  endfunction

  function automatic void start_frame();
    tx_q.delete();
    rd_pos.delete();
    rd_exp.delete();
    n_txn = 0;
  endfunction

  function automatic void add_txn(input logic [7:0] cmd, input logic [31:0] addr,
                                  input logic [31:0] data);
    int idx;
    idx = int'(addr[31:2] % 30'(DEPTH));
    push_bits(32'(cmd), 8);
    case (cmd)
      8'h01: begin
        push_bits(data, 8);
        cfg_m = data[7:0];
      end
      8'h07: begin
        tx_q.push_back(1'($urandom));
        rd_pos.push_back(tx_q.size());
        rd_exp.push_back({24'h0, cfg_m});
        push_bits($urandom, 32);
      end
      8'h02: begin
        push_bits(addr, 32);
        push_bits(data, 32);
        mem_m[idx] = data;
      end
      8'h0B: begin
        push_bits(addr, 32);
        repeat (DUMMY) tx_q.push_back(1'($urandom));
        rd_pos.push_back(tx_q.size());
        rd_exp.push_back(mem_m[idx]);
        push_bits($urandom, 32);
      end
      default: repeat (40) tx_q.push_back(1'($urandom));
    endcase
    n_txn++;
  endfunction

  // Send tx_q (or its first 'cut' bits) with half period h clk cycles; sample sdo before each rise.
  task automatic run_frame(input int h, input int cut, input bit raise_cs);
    int lim;
    lim = (cut < 0) ? tx_q.size() : cut;
    rx_q.delete();
    en_cnt = 0;
    spi_if.spi_cs = 1'b0;
    repeat (h + 2) @(negedge clk_i);
    for (int i = 0; i < lim; i++) begin
      spi_if.spi_sdi = tx_q[i];
      repeat (h) @(negedge clk_i);
      rx_q.push_back(spi_if.spi_sdo);
      if (spi_if.spi_sdo_en === 1'b1) en_cnt++;
      spi_if.spi_sclk = 1'b1;
      repeat (h) @(negedge clk_i);
      spi_if.spi_sclk = 1'b0;
    end
    repeat (h + 3) @(negedge clk_i);
    if (raise_cs) begin
      spi_if.spi_cs = 1'b1;
      repeat (6) @(negedge clk_i);
    end
  endtask

  task automatic check_reads(input string tag);
    for (int k = 0; k < rd_pos.size(); k++) begin
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) w = {w[30:0], logic'(rx_q[rd_pos[k] + i])};
      chk({tag, "_rd"}, w, rd_exp[k]);
    end
    chk({tag, "_en"}, 32'(en_cnt), 32'(32 * rd_pos.size()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    spi_if.spi_sclk = 1'b0;
    spi_if.spi_sdi  = 1'b0;
    spi_if.spi_cs   = 1'b1;
    rst_i = 1'b1;
    cfg_m = 8'h00;
    repeat (3) @(negedge clk_i);
    chk("rst_sdo", 32'(spi_if.spi_sdo), 32'h0);
    chk("rst_sdo_en", 32'(spi_if.spi_sdo_en), 32'h0);
    chk("rst_cfg", 32'(cfg_o), 32'h0);
    chk("rst_cmd", 32'(cmd_o), 32'h0);
    chk("rst_done", 32'(frame_done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // WRREG at sclk = clk/2; cfg must update before cs rises, frame_done only after
    start_frame(); add_txn(8'h01, 0, 32'hA5);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(1, -1, 0);
    chk("wrreg_cfg_early", 32'(cfg_o), 32'hA5);
    chk("wrreg_no_done_yet", 32'(done_cnt - d0), 0);
    spi_if.spi_cs = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("wrreg_cmd", 32'(cmd_o), 32'h01);
    chk("wrreg_done", 32'(done_cnt - d0), 1);
    chk("wrreg_err", 32'(err_cnt - e0), 0);

    // WRMEM then RDMEM
    start_frame(); add_txn(8'h02, 32'h8, 32'hDEADBEEF); run_frame(1, -1, 1);
    start_frame(); add_txn(8'h0B, 32'h8, 0); run_frame(3, -1, 1);
    check_reads("rdmem8");
    chk("rdmem_en_off", 32'(spi_if.spi_sdo_en), 0);

    // RDREG
    start_frame(); add_txn(8'h01, 0, 32'h3C); run_frame(2, -1, 1);
    start_frame(); add_txn(8'h07, 0, 0); run_frame(4, -1, 1);
    check_reads("rdreg");

    // Unknown command
    start_frame(); add_txn(8'h55, 0, 0);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(2, -1, 1);
    chk("unk_err", 32'(err_cnt - e0), 1);
    chk("unk_done", 32'(done_cnt - d0), 0);
    chk("unk_cfg", 32'(cfg_o), 32'h3C);
    chk("unk_cmd", 32'(cmd_o), 32'h55);

    // Aborted WRMEM leaves memory untouched
    start_frame(); add_txn(8'h02, 32'h4, 32'h12345678); run_frame(1, -1, 1);
    start_frame();
    push_bits(32'h02, 8); push_bits(32'h4, 32); push_bits(32'hCAFEF00D, 32);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(3, 8 + 32 + 20, 1);
    chk("abort_err", 32'(err_cnt - e0), 1);
    chk("abort_done", 32'(done_cnt - d0), 0);
    start_frame(); add_txn(8'h0B, 32'h4, 0); run_frame(3, -1, 1);
    check_reads("abort_rd");

    // Index wrap: 0x44 aliases 0x04
    start_frame(); add_txn(8'h02, 32'h44, 32'h0BADCAFE); run_frame(1, -1, 1);
    start_frame(); add_txn(8'h0B, 32'h04, 0); run_frame(3, -1, 1);
    check_reads("wrap");

    // Fill memory, then random (possibly back-to-back) transactions
    for (int i = 0; i < DEPTH; i++) begin
      start_frame(); add_txn(8'h02, 32'(i * 4), $urandom); run_frame(1, -1, 1);
    end
    for (int f = 0; f < 20; f++) begin
      int ntx;
      ntx = 1 + int'($urandom_range(0, 1));
      start_frame();
      for (int t = 0; t < ntx; t++) begin
        logic [7:0] c;
        case ($urandom_range(0, 3))
          0: c = 8'h01;
          1: c = 8'h07;
          2: c = 8'h02;
          default: c = 8'h0B;
        endcase
        add_txn(c, $urandom, $urandom);
      end
      d0 = done_cnt; e0 = err_cnt;
      run_frame(3 + int'($urandom_range(0, 1)), -1, 1);
      check_reads($sformatf("rand%0d", f));
      chk($sformatf("rand%0d_done", f), 32'(done_cnt - d0), 32'(ntx));
      chk($sformatf("rand%0d_err", f), 32'(err_cnt - e0), 0);
      chk($sformatf("rand%0d_cfg", f), 32'(cfg_o), 32'(cfg_m));
    end

    // Reset in the middle of an RDMEM data phase
    start_frame(); add_txn(8'h0B, 32'h8, 0);
    run_frame(3, 8 + 32 + DUMMY + 10, 0);
    chk("midrst_en_before", 32'(spi_if.spi_sdo_en), 1);
    rst_i = 1'b1;
    #1;
    chk("midrst_en", 32'(spi_if.spi_sdo_en), 0);
    chk("midrst_sdo", 32'(spi_if.spi_sdo), 0);
    chk("midrst_cfg", 32'(cfg_o), 0);
    chk("midrst_cmd", 32'(cmd_o), 0);
    spi_if.spi_cs = 1'b1;
    cfg_m = 8'h00;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    start_frame(); add_txn(8'h01, 0, 32'h5A);
    d0 = done_cnt;
    run_frame(2, -1, 1);
    chk("postrst_cfg", 32'(cfg_o), 32'h5A);
    chk("postrst_done", 32'(done_cnt - d0), 1);
    start_frame(); add_txn(8'h0B, 32'h8, 0); run_frame(3, -1, 1);
    check_reads("postrst_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI responder (target end) for the stimulus SPI master frames: CS low, 8-bit command, optional 32-bit address, dummy bits, data.
- Decodes each frame into an 8-bit config register and a small word memory. Drives read data back on spi_sdo.
- Used as the on-FPGA loopback/reference target to validate stimulus ROMs before the DUT is connected.
- All SPI pins are sampled synchronously in the clk_i domain.

Parameters:
- MEM_DEPTH, 16, number of 32-bit memory words; power of 2, at least 2.
- DUMMY_BITS, 34, dummy bits between address and read data for RDMEM.
- SYNC_STAGES, 2, synchronizer depth applied equally to spi_sclk, spi_sdi and spi_cs.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- spi_sclk  in  1  SPI clock from master
- spi_sdi  in  1  SPI data from master
- spi_cs  in  1  chip select, active low
- spi_sdo  out  1  read data to master
- spi_sdo_en  out  1  high while read data bits are driven
- cfg_o  out  8  config register
- cmd_o  out  8  last fully received command byte
- frame_done  out  1  one-cycle pulse when a frame completes normally
- err  out  1  one-cycle pulse on unknown command or aborted frame

Behaviour:
- Reset values: spi_sdo=0, spi_sdo_en=0, cfg_o=0, cmd_o=0, frame_done=0, err=0, state=IDLE, synchronizers=1 for cs and 0 for sclk/sdi. Memory is not reset.
- Synchronization and edge detection:
  - sclk, sdi and cs pass through SYNC_STAGES flops. A rise or fall is detected by comparing the last stage with one extra flop.
  - Each sclk phase must last at least 1 clk_i cycle. The master's sclk = clk_i/2 is supported.
- Sampling: sdi is sampled on a detected sclk rise, MSB first, into a 32-bit shift register. A bit counter counts down per field.
- Output timing: spi_sdo and spi_sdo_en update on a detected sclk fall, i.e. SYNC_STAGES+1 clk_i cycles after the pin edge.
- Commands:
  - 0x01 WRREG: 8 data bits. cfg_o is updated on the 8th bit.
  - 0x07 RDREG: 1 dummy bit, then 32 bits {24'h0, cfg_o} out.
  - 0x02 WRMEM: 32 address bits, then 32 data bits. The word is written to mem[addr[log2(MEM_DEPTH)+1:2]] on the 32nd data bit.
  - 0x0B RDMEM: 32 address bits, then DUMMY_BITS dummy bits, then 32 bits of mem[index] out.
- Addressing: address bits above the index and addr[1:0] are ignored. The index wraps modulo MEM_DEPTH.
- States and transitions:
  - IDLE: go to CMD on a synchronized cs fall; bit counter = 7.
  - CMD: on the 8th bit, set cmd_o. Then go to WDATA (8) for 0x01, DUMMY (1) for 0x07, ADDR (32) for 0x02 or 0x0B.
  - Unknown command: pulse err, go to SKIP.
  - ADDR: after 32 bits, latch the index. Go to WDATA (32) for 0x02, DUMMY (DUMMY_BITS) for 0x0B.
  - DUMMY: ignore sdi. On the last dummy rise, load the read word into the output shifter.
  - RDATA: on the first fall after load, drive bit 31 and set spi_sdo_en=1. Shift out on each subsequent fall.
  - Read end: after the 32nd rise, go to END. spi_sdo_en clears on the next fall or cs rise.
  - WDATA: after the last bit, commit the write and go to END.
  - END: extra sclk edges are ignored. On cs rise, pulse frame_done, go to IDLE.
  - SKIP: ignore everything until cs rise, then go to IDLE with no frame_done.
- Back-to-back frames: a new command byte may follow in the same CS window. END goes straight to CMD on the next sclk rise, and frame_done pulses at the end of each transaction.
- Abort: cs rise while in CMD, ADDR, DUMMY, RDATA or WDATA pulses err and goes to IDLE. No register or memory write is committed; spi_sdo_en=0 and spi_sdo=0 immediately.
- Simultaneous cs rise and sclk rise in the same cycle: cs wins. The bit is discarded.
- rst_i mid-frame: everything returns to reset values immediately, asynchronously.

Test Plan:
- WRREG 0x01, data 0xA5, cs high -> cfg_o=0xA5 on the 8th data rise, cmd_o=0x01, one frame_done, err=0.
- WRMEM 0x02, addr 0x0000_0008, data 0xDEAD_BEEF; then RDMEM 0x0B, addr 0x8, 34 dummy bits -> 32 bits 0xDEADBEEF on spi_sdo MSB first, spi_sdo_en high for exactly 32 bit periods.
- RDREG 0x07 after cfg_o=0x3C -> 1 dummy bit, then 0x0000003C on spi_sdo.
- Command 0x55 followed by 40 sclk cycles -> err pulse at the 8th bit, no writes, no frame_done, cfg_o unchanged.
- WRMEM addr 0x4, cs raised after 20 data bits -> err pulse, mem[1] unchanged (readback returns the previous value).
- Address wrap with MEM_DEPTH=16: write addr 0x44 -> readback at addr 0x04 returns the same word.
- rst_i asserted mid-RDMEM -> spi_sdo_en=0, state=IDLE within the same cycle. The next frame decodes correctly.
